wb_dest_sel_skid: RTL and testbench
===================================

Name: wb_dest_sel_skid

Overview:
- Parametrised successor to the 2:1 write-register-address select.
- Picks the writeback destination address from N_SRC candidates (rt, rd, link register, ...) using a select code.
- Applies write-enable qualification: zero-register suppression and illegal-select trapping.
- Presents the result through a registered valid/ready stage with a one-entry skid buffer, so the writeback stage can stall without losing or reordering beats.

Parameters:
- ADDR_W, 5: width of a register address.
- N_SRC, 3: number of candidate destination addresses (min 2).
- SEL_W, $clog2(N_SRC) (min 1): width of the select code.
- DROP_ZERO, 1: when 1, a beat whose chosen address is 0 leaves with we_out=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- sel  in  SEL_W  source select; index i chooses addr_in[i*ADDR_W +: ADDR_W].
- addr_in  in  N_SRC*ADDR_W  packed candidate addresses, source 0 in the LSBs.
- we_in  in  1  requested register write enable.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- waddr_out  out  ADDR_W  selected write address.
- we_out  out  1  qualified write enable.
- sel_err  out  1  beat carries an illegal select (sel >= N_SRC).

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, waddr_out=0, we_out=0, sel_err=0.
  - Skid entry is invalid, so in_ready=1 as soon as reset releases.
  - Any buffered beats are discarded, including reset asserted mid-stall.
- Accept condition: in_valid & in_ready at the rising edge.
- Per-beat computation, combinational before registering:
  - sel < N_SRC: addr = addr_in[sel]; err = 0; we = we_in & ~(DROP_ZERO & (addr==0)).
  - sel >= N_SRC: addr = 0; we = 0; err = 1.
- Storage is two entries: main (drives the outputs) and skid. Each entry holds {addr, we, err, valid}.
- in_ready = ~skid.valid. It is a registered-state function only; there is no combinational path from out_ready.
- Latency: an accepted beat appears on the outputs the next cycle when main is empty or being drained.
- Per-edge update rules, with drain = out_valid & out_ready:
  - Accept with main empty, or accept with drain: main <= new beat.
  - Accept with main full and no drain: skid <= new beat; main holds.
  - Drain with skid valid: main <= skid; skid.valid <= 0. No accept is possible in this case because in_ready=0.
  - Drain, no skid, no accept: main.valid <= 0.
  - No drain: main holds its values stable. AXI-style rule: no change while valid and not ready.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- sel_err is qualified by out_valid; it is 0 whenever out_valid=0.
- Outputs are held at their last values when out_valid=0. Consumers must qualify with out_valid.
- Throughput is one beat per cycle when out_ready stays high.

Decomposition:
- Shared package wb_pkg holds:
  - constant REG_ADDR_W=5;
  - constant ZERO_REG=5'd0;
  - typedef wb_beat_t {addr, we, err}, reused by the register-file write port.
- One natural sub-module, skid_buf, is a generic 2-entry valid/ready buffer parametrised by payload width. The top level does the select/qualify and packs the payload.

Test Plan:
- Reset release, in_valid=0 -> in_ready=1, out_valid=0, waddr_out=0, we_out=0, sel_err=0.
- Streaming, out_ready=1: addr_in={5'd31,5'd7,5'd3}, we_in=1, sel=0,1,2 on consecutive cycles -> waddr_out=3, 7, 31 on the following three cycles with we_out=1; in_ready stays 1.
- Stall: out_ready=0, push beats sel=1 then sel=2 -> in_ready falls after the second accept and out_valid/waddr_out=7 hold. Raise out_ready -> 7 then 31 drain in order, and in_ready returns to 1 the cycle after the skid empties.
- Zero-register suppression: DROP_ZERO=1, addr_in[0]=0, sel=0, we_in=1 -> out_valid=1, waddr_out=0, we_out=0. With DROP_ZERO=0 -> we_out=1.
- Illegal select: N_SRC=3, sel=3, we_in=1 -> waddr_out=0, we_out=0, sel_err=1 for that beat only; next legal beat shows sel_err=0.
- Reset during stall, with main and skid both full -> after rst asserts: out_valid=0 immediately (asynchronous), in_ready=1 after release, and no stale beat appears after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback definitions.
// Used by the destination select and the register-file write port.
package wb_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic                  we;
        logic                  err;
    } wb_beat_t;

    localparam int WB_BEAT_W = $bits(wb_beat_t);

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer, main plus skid.
// in_ready depends on registered state only.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         m_valid;
    logic [W-1:0] m_data;
    logic         s_valid;
    logic [W-1:0] s_data;

    logic         m_valid_n;
    logic [W-1:0] m_data_n;
    logic         s_valid_n;
    logic [W-1:0] s_data_n;

    logic         acc;
    logic         drain;

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;

    assign acc   = in_valid & ~s_valid;
    assign drain = m_valid & out_ready;

    // Next-state: refill main from skid first, else take the new beat.
    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        if (drain && s_valid) begin
            m_data_n  = s_data;
            s_valid_n = 1'b0;
        end else if (acc && (!m_valid || drain)) begin
            m_valid_n = 1'b1;
            m_data_n  = in_data;
        end else if (acc) begin
            s_valid_n = 1'b1;
            s_data_n  = in_data;
        end else if (drain) begin
            m_valid_n = 1'b0;
        end
    end

    // State registers; reset discards both entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            s_valid <= s_valid_n;
            s_data  <= s_data_n;
        end
    end

endmodule

// File: rtl/wb_dest_sel_skid.sv
// Writeback destination select with write-enable qualification.
// Result is presented through a registered skid stage.
module wb_dest_sel_skid
    import wb_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int N_SRC     = 3,
    parameter int SEL_W     = (N_SRC > 2) ? $clog2(N_SRC) : 1,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_SRC*ADDR_W-1:0] addr_in,
    input  logic                    we_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       waddr_out,
    output logic                    we_out,
    output logic                    sel_err
);

    localparam int PW = ADDR_W + 2;

    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              err;
    logic [PW-1:0]     pay_in;
    logic [PW-1:0]     pay_out;

    // Pick the addressed candidate; an unmatched code is an illegal select.
    always_comb begin
        hit  = 1'b0;
        addr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                hit  = 1'b1;
                addr = addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Qualify the write enable.
    always_comb begin
        err = ~hit;
        we  = 1'b0;
        if (hit) begin
            we = we_in
               & ~(DROP_ZERO & (addr == ADDR_W'(ZERO_REG)));
        end
    end

    assign pay_in = {addr, we, err};

    skid_buf #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign waddr_out = pay_out[PW-1:2];
    assign we_out    = pay_out[1];
    assign sel_err   = pay_out[0] & out_valid;

endmodule

// File: tb/tb_wb_dest_sel_skid.sv
// Directed bench for wb_dest_sel_skid.
// Second instance covers DROP_ZERO=0.
module tb_wb_dest_sel_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [14:0] addr_in = '0;
    logic        we_in = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, we_out, sel_err;
    logic [4:0]  waddr_out;
    logic        in_ready2, out_valid2, we_out2, sel_err2;
    logic [4:0]  waddr_out2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_dest_sel_skid #(
        .ADDR_W(5), .N_SRC(3), .DROP_ZERO(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .addr_in(addr_in), .we_in(we_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .waddr_out(waddr_out), .we_out(we_out),
        .sel_err(sel_err)
    );

    wb_dest_sel_skid #(
        .ADDR_W(5), .N_SRC(3), .DROP_ZERO(1'b0)
    ) dut_nz (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2),
        .sel(sel), .addr_in(addr_in), .we_in(we_in),
        .out_valid(out_valid2), .out_ready(out_ready),
        .waddr_out(waddr_out2), .we_out(we_out2),
        .sel_err(sel_err2)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out_is(input string tag,
                          input logic v, input logic [4:0] a,
                          input logic w, input logic e);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".addr"},  32'(waddr_out), 32'(a));
        chk({tag, ".we"},    32'(we_out),    32'(w));
        chk({tag, ".err"},   32'(sel_err),   32'(e));
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        out_is("rst_async", 1'b0, 5'd0, 1'b0, 1'b0);
        #10 rst = 1'b1;
        step();
        out_is("rst_rel", 1'b0, 5'd0, 1'b0, 1'b0);
        chk("rst_rel.in_ready", 32'(in_ready), 32'd1);

        // streaming
        addr_in  = {5'd31, 5'd7, 5'd3};
        we_in    = 1'b1;
        in_valid = 1'b1;
        sel      = 2'd0;
        step();
        out_is("str0", 1'b1, 5'd3, 1'b1, 1'b0);
        chk("str0.in_ready", 32'(in_ready), 32'd1);
        sel = 2'd1;
        step();
        out_is("str1", 1'b1, 5'd7, 1'b1, 1'b0);
        chk("str1.in_ready", 32'(in_ready), 32'd1);
        sel = 2'd2;
        step();
        out_is("str2", 1'b1, 5'd31, 1'b1, 1'b0);
        chk("str2.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
        out_is("str_idle", 1'b0, 5'd31, 1'b1, 1'b0);

        // stall with skid fill
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        out_is("stl0", 1'b1, 5'd7, 1'b1, 1'b0);
        chk("stl0.in_ready", 32'(in_ready), 32'd1);
        sel = 2'd2;
        step();
        out_is("stl1", 1'b1, 5'd7, 1'b1, 1'b0);
        chk("stl1.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();
        out_is("stl2", 1'b1, 5'd7, 1'b1, 1'b0);
        chk("stl2.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_is("drn0", 1'b1, 5'd31, 1'b1, 1'b0);
        chk("drn0.in_ready", 32'(in_ready), 32'd1);
        step();
        chk("drn1.valid", 32'(out_valid), 32'd0);

        // zero-register suppression
        addr_in  = {5'd31, 5'd7, 5'd0};
        in_valid = 1'b1;
        sel      = 2'd0;
        step();
        out_is("zero", 1'b1, 5'd0, 1'b0, 1'b0);
        chk("zero_nz.valid", 32'(out_valid2), 32'd1);
        chk("zero_nz.we", 32'(we_out2), 32'd1);

        // illegal select
        sel = 2'd3;
        step();
        out_is("ill", 1'b1, 5'd0, 1'b0, 1'b1);
        chk("ill_nz.we", 32'(we_out2), 32'd0);
        chk("ill_nz.err", 32'(sel_err2), 32'd1);
        sel = 2'd1;
        step();
        out_is("legal", 1'b1, 5'd7, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        chk("idle.valid", 32'(out_valid), 32'd0);
        chk("idle.err", 32'(sel_err), 32'd0);

        // reset while both entries are full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step();
        sel = 2'd2;
        step();
        in_valid = 1'b0;
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.valid", 32'(out_valid), 32'd1);
        #3 rst = 1'b0;
        #1;
        out_is("mid_rst", 1'b0, 5'd0, 1'b0, 1'b0);
        chk("mid_rst.in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post0.valid", 32'(out_valid), 32'd0);
        chk("post0.in_ready", 32'(in_ready), 32'd1);
        step();
        chk("post1.valid", 32'(out_valid), 32'd0);
        chk("post1.addr", 32'(waddr_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
